// File: rtl/logic_gates_pkg.sv
// Shared opcode encodings for the registered bitwise logic block.
package logic_gates_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOTA = 4'd6;
  localparam logic [3:0] OP_NOTB = 4'd7;
  localparam logic [3:0] OP_BUFA = 4'd8;
  localparam logic [3:0] OP_BUFB = 4'd9;
  localparam logic [3:0] OP_LAST = 4'd9;

endpackage

// File: rtl/logic_gates_pipe_if.sv
// Operand/result handshake bundle for logic_gates_pipe.
interface logic_gates_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             use_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             op_err;

  modport master (
    output in_valid, a, b, op, use_acc, acc_clr, out_ready,
    input  in_ready, out_valid, y, zero, parity, op_err
  );

  modport slave (
    input  in_valid, a, b, op, use_acc, acc_clr, out_ready,
    output in_ready, out_valid, y, zero, parity, op_err
  );
endinterface

// File: rtl/logic_gates_core.sv
// Combinational bitwise function unit; illegal opcodes yield zero and flag err.
module logic_gates_core
  import logic_gates_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = (op > OP_LAST);
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      OP_BUFA: y = a;
      OP_BUFB: y = b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gates_pipe.sv
// Single-stage registered logic unit with valid/ready handshake and accumulator chaining.
module logic_gates_pipe
  import logic_gates_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic               clk,
  input logic               rst_n,
  logic_gates_pipe_if.slave bus
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_eff_p0;
  logic [WIDTH-1:0] res_p0;
  logic             err_p0;
  logic             accept_p0;

  logic [WIDTH-1:0] y_p1;
  logic             zero_p1;
  logic             parity_p1;
  logic             err_p1;
  logic             vld_p1;

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept_p0    = bus.in_valid && bus.in_ready;
  assign a_eff_p0     = bus.use_acc ? acc_q : bus.a;

  logic_gates_core #(.WIDTH(WIDTH)) u_core (
    .a   (a_eff_p0),
    .b   (bus.b),
    .op  (bus.op),
    .y   (res_p0),
    .err (err_p0)
  );

  // p0 -> p1: output register and accumulator update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1      <= '0;
      zero_p1   <= 1'b1;
      parity_p1 <= 1'b0;
      err_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      acc_q     <= ACC_INIT;
    end else begin
      if (accept_p0) begin
        y_p1      <= res_p0;
        zero_p1   <= ~|res_p0;
        parity_p1 <= ^res_p0;
        err_p1    <= err_p0;
        vld_p1    <= 1'b1;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      // A clear wins over a load; an accept this cycle already read the old acc.
      if (bus.acc_clr)
        acc_q <= ACC_INIT;
      else if (accept_p0 && !err_p0)
        acc_q <= res_p0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.y         = y_p1;
  assign bus.zero      = zero_p1;
  assign bus.parity    = parity_p1;
  assign bus.op_err    = err_p1;

endmodule
